prefetch_op_sched: RTL and testbench
====================================

PREFETCH_OP_SCHED -- requirements
Module: prefetch_op_sched

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_BITS, 64, address width; LOG_BLOCK_DATA_BYTES, 6, log2 block bytes (BLK = 8<<LOG_BLOCK_DATA_BYTES bits); ERR_CNT_WIDTH, 8, error counter width.
REQ-002 SHALL have ports (name, direction, width, meaning): clk in 1 clock; reset in 1 async active-high reset; crs_enable in 1 scheduler enable; crs_flush in 1 drain request; crs_clearErr in 1 leave ERROR.
REQ-003 SHALL have master ports: m_ar_valid in 1; m_ar_addr in ADDR_BITS; m_ar_ready out 1; m_r_valid out 1; m_r_ready in 1; m_r_data out BLK; m_r_last out 1.
REQ-004 SHALL have slave/prefetch ports: s_r_valid in 1; s_r_data in BLK; s_r_last in 1; s_r_ready out 1; pf_valid in 1; pf_addr in ADDR_BITS; pf_ready out 1.
REQ-005 SHALL have datapath ports: dp_opcode out 3; dp_addr out ADDR_BITS; dp_data out BLK; dp_last out 1; dp_respData in BLK; dp_respLast in 1; dp_prRValid in 1; dp_almostFull in 1; dp_hasOutstanding in 1; dp_errorCode in 3.
REQ-006 SHALL have status ports: state out 2; errCode out 3; errCnt out ERR_CNT_WIDTH.

Function
REQ-007 SHALL issue at most one datapath opcode per cycle, combinationally from the current cycle's grant (zero latency); opcodes: 0 NOP, 1 prefetch req, 2 master AR, 3 slave R data, 4 promise read.
REQ-008 SHALL grant in this priority: slave R (op 3) first; then master AR (op 2) vs promise read (op 4) by 2-way round-robin; prefetch (op 1) last.
REQ-009 Promise-read candidate SHALL be m_r_valid & m_r_ready, where m_r_valid = dp_prRValid & state!=ERROR; m_r_data/m_r_last SHALL be dp_respData/dp_respLast passed through.
REQ-010 Round-robin pointer SHALL toggle only on a cycle where both AR and promise read were candidates and one was granted; it SHALL favour the non-granted one next.
REQ-011 Prefetch SHALL be granted only when state==RUN, pf_valid=1, dp_almostFull=0 and no higher-priority grant.
REQ-012 *_ready outputs SHALL equal the grant for that source; dp_addr SHALL be m_ar_addr on op 2, pf_addr on op 1, else 0; dp_data/dp_last SHALL be s_r_data/s_r_last on op 3, else 0.
REQ-013 FSM states: IDLE=0, RUN=1, DRAIN=2, ERROR=3.
REQ-014 IDLE: ops 3, 4 allowed, ops 1, 2 blocked; crs_enable=1 -> RUN.
REQ-015 RUN: all ops allowed; crs_flush=1 or crs_enable=0 -> DRAIN (flush and enable-drop equivalent).
REQ-016 DRAIN: ops 3, 4 allowed, ops 1, 2 blocked; -> IDLE when dp_hasOutstanding=0 and dp_prRValid=0.
REQ-017 Any state except ERROR: a qualified error -> ERROR, taking precedence over other transitions; ERROR blocks all grants (opcode 0); crs_clearErr=1 -> IDLE.
REQ-018 A registered lastOp SHALL hold the previous cycle's dp_opcode; dp_errorCode is qualified when nonzero, except that code 1 SHALL be ignored when lastOp==0 (datapath reports NOP as invalid opcode).
REQ-019 errCode SHALL capture the first qualified error code and hold it until crs_clearErr.

Reset
REQ-020 On reset: state=IDLE, RR pointer favours AR, lastOp=0, errCode=0, errCnt=0; all ready/valid outputs 0 and dp_opcode=0 while reset is asserted.
REQ-021 Reset asserted mid-transfer SHALL abort immediately with no completing grant; the datapath is reset concurrently by its owner.

Configuration
REQ-022 Macro PREFETCH_OP_SCHED_ERRCNT_EN defined: errCnt SHALL count every qualified error, saturate at all-ones, and clear on crs_clearErr; undefined: errCnt tied 0 and no counter flops exist; errCode/ERROR behaviour is unchanged in both builds.

Structure
REQ-023 Package prefetch_sched_pkg SHALL hold the opcode enum (3 bits), the error-code constants (0 none, 1 bad opcode, 2 full, 3 not ready, 4 overflow) and the state enum (2 bits).
REQ-024 The AR/promise round-robin SHALL be a sub-module rr_arb2 (2 requests, pointer flop, one-hot grant).

Verification
REQ-025 RUN, s_r_valid=1 together with m_ar_valid=1 and pf_valid=1 -> dp_opcode=3, s_r_ready=1, m_ar_ready=0, pf_ready=0.
REQ-026 AR and promise read continuously pending for 4 cycles -> opcodes 2,4,2,4.
REQ-027 dp_almostFull=1, pf_valid=1, others idle -> dp_opcode=0, pf_ready=0; deassert almostFull -> op 1 next cycle, dp_addr=pf_addr.
REQ-028 RUN, crs_flush pulse, dp_hasOutstanding=1 for 3 cycles -> state=2 with m_ar_ready=0, then state=0 the cycle after dp_hasOutstanding=dp_prRValid=0.
REQ-029 dp_errorCode=1 after a NOP -> no state change; dp_errorCode=2 after op 2 -> state=3, errCode=2, errCnt=1 (macro defined) or 0 (undefined).
REQ-030 Reset asserted while state=RUN with grants active -> the same cycle all readies=0 and dp_opcode=0; after release state=0 and errCode=0.

Source files
------------

// File: rtl/prefetch_sched_pkg.sv
// Shared opcode, error-code and state definitions for the prefetch operation scheduler.
package prefetch_sched_pkg;

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_PREFETCH   = 3'd1,
        OP_MASTER_AR  = 3'd2,
        OP_SLAVE_R    = 3'd3,
        OP_PROMISE_RD = 3'd4
    } opcodeT;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_BAD_OPCODE = 3'd1;
    localparam logic [2:0] ERR_FULL       = 3'd2;
    localparam logic [2:0] ERR_NOT_READY  = 3'd3;
    localparam logic [2:0] ERR_OVERFLOW   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERROR = 2'd3
    } schedStateT;

    // The datapath flags a NOP as a bad opcode, so that one report is not a real error.
    function automatic logic isQualifiedErr(input logic [2:0] code, input opcodeT lastOp);
        return (code != ERR_NONE) && !((code == ERR_BAD_OPCODE) && (lastOp == OP_NOP));
    endfunction

endpackage

// File: rtl/prefetch_op_sched_rr_arb2.sv
// Two-request round-robin arbiter with a one-hot grant; req[0] is favoured out of reset.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic ptrReg;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptrReg ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // Only a contended grant moves the pointer, handing priority to the loser.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptrReg <= 1'b0;
        end else if (en && (req == 2'b11)) begin
            ptrReg <= ~ptrReg;
        end
    end

endmodule

// File: rtl/prefetch_op_sched.sv
// Single-opcode-per-cycle scheduler for slave R, master AR, promise read and prefetch.
// Optional error counter enabled by defining PREFETCH_OP_SCHED_ERRCNT_EN.
module prefetch_op_sched
    import prefetch_sched_pkg::*;
#(
    parameter int ADDR_BITS            = 64,
    parameter int LOG_BLOCK_DATA_BYTES = 6,
    parameter int ERR_CNT_WIDTH        = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  crs_enable,
    input  logic                                  crs_flush,
    input  logic                                  crs_clearErr,
    input  logic                                  m_ar_valid,
    input  logic [ADDR_BITS-1:0]                  m_ar_addr,
    output logic                                  m_ar_ready,
    output logic                                  m_r_valid,
    input  logic                                  m_r_ready,
    output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]  m_r_data,
    output logic                                  m_r_last,
    input  logic                                  s_r_valid,
    input  logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]  s_r_data,
    input  logic                                  s_r_last,
    output logic                                  s_r_ready,
    input  logic                                  pf_valid,
    input  logic [ADDR_BITS-1:0]                  pf_addr,
    output logic                                  pf_ready,
    output logic [2:0]                            dp_opcode,
    output logic [ADDR_BITS-1:0]                  dp_addr,
    output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]  dp_data,
    output logic                                  dp_last,
    input  logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]  dp_respData,
    input  logic                                  dp_respLast,
    input  logic                                  dp_prRValid,
    input  logic                                  dp_almostFull,
    input  logic                                  dp_hasOutstanding,
    input  logic [2:0]                            dp_errorCode,
    output logic [1:0]                            state,
    output logic [2:0]                            errCode,
    output logic [ERR_CNT_WIDTH-1:0]              errCnt
);

    localparam int BLK = 8 << LOG_BLOCK_DATA_BYTES;

    schedStateT stateReg, stateNext;
    opcodeT     lastOpReg;
    opcodeT     opcode;
    logic [2:0] errCodeReg;

    logic       active;
    logic       notErr;
    logic       isRun;
    logic       srCand;
    logic       arCand;
    logic       prCand;
    logic       pfGrant;
    logic [1:0] rrGrant;
    logic       errQual;
    logic       clearNow;

    // Asynchronous reset must silence every grant in the very cycle it rises.
    assign active  = ~reset;
    assign notErr  = (stateReg != ST_ERROR);
    assign isRun   = (stateReg == ST_RUN);

    assign srCand    = active & notErr & s_r_valid;
    assign m_r_valid = active & notErr & dp_prRValid;
    assign m_r_data  = dp_respData;
    assign m_r_last  = dp_respLast;
    assign arCand    = active & isRun & m_ar_valid;
    assign prCand    = m_r_valid & m_r_ready;

    rr_arb2 uArb (
        .clk   (clk),
        .reset (reset),
        .en    (~srCand),
        .req   ({prCand, arCand}),
        .grant (rrGrant)
    );

    assign pfGrant = active & isRun & pf_valid & ~dp_almostFull & ~srCand & ~(|rrGrant);

    always_comb begin
        opcode = OP_NOP;
        if (srCand) begin
            opcode = OP_SLAVE_R;
        end else if (rrGrant[0]) begin
            opcode = OP_MASTER_AR;
        end else if (rrGrant[1]) begin
            opcode = OP_PROMISE_RD;
        end else if (pfGrant) begin
            opcode = OP_PREFETCH;
        end
    end

    assign dp_opcode  = opcode;
    assign s_r_ready  = (opcode == OP_SLAVE_R);
    assign m_ar_ready = (opcode == OP_MASTER_AR);
    assign pf_ready   = (opcode == OP_PREFETCH);

    always_comb begin
        dp_addr = '0;
        dp_data = '0;
        dp_last = 1'b0;
        case (opcode)
            OP_MASTER_AR: dp_addr = m_ar_addr;
            OP_PREFETCH:  dp_addr = pf_addr;
            OP_SLAVE_R: begin
                dp_data = s_r_data[BLK-1:0];
                dp_last = s_r_last;
            end
            default: ;
        endcase
    end

    assign errQual  = isQualifiedErr(dp_errorCode, lastOpReg);
    assign clearNow = (stateReg == ST_ERROR) & crs_clearErr;

    always_comb begin
        stateNext = stateReg;
        if (notErr && errQual) begin
            stateNext = ST_ERROR;
        end else begin
            case (stateReg)
                ST_IDLE:  if (crs_enable) stateNext = ST_RUN;
                ST_RUN:   if (crs_flush || !crs_enable) stateNext = ST_DRAIN;
                ST_DRAIN: if (!dp_hasOutstanding && !dp_prRValid) stateNext = ST_IDLE;
                ST_ERROR: if (crs_clearErr) stateNext = ST_IDLE;
                default:  stateNext = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg   <= ST_IDLE;
            lastOpReg  <= OP_NOP;
            errCodeReg <= ERR_NONE;
        end else begin
            stateReg  <= stateNext;
            lastOpReg <= opcode;
            if (clearNow) begin
                errCodeReg <= ERR_NONE;
            end else if ((errCodeReg == ERR_NONE) && errQual) begin
                errCodeReg <= dp_errorCode;
            end
        end
    end

    assign state   = stateReg;
    assign errCode = errCodeReg;

`ifdef PREFETCH_OP_SCHED_ERRCNT_EN
    logic [ERR_CNT_WIDTH-1:0] errCntReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            errCntReg <= '0;
        end else if (clearNow) begin
            errCntReg <= '0;
        end else if (errQual && (errCntReg != {ERR_CNT_WIDTH{1'b1}})) begin
            errCntReg <= errCntReg + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign errCnt = errCntReg;
`else
    assign errCnt = '0;
`endif

endmodule

// File: tb/tb_prefetch_op_sched.sv
// Randomised and directed checks of prefetch_op_sched against a cycle-level behavioural model.
module tb_prefetch_op_sched;

    localparam int AW  = 64;
    localparam int BLK = 512;
    localparam int ECW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic           crs_enable, crs_flush, crs_clearErr;
    logic           m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, m_r_last;
    logic [AW-1:0]  m_ar_addr, pf_addr, dp_addr;
    logic [BLK-1:0] m_r_data, s_r_data, dp_data, dp_respData;
    logic           s_r_valid, s_r_last, s_r_ready, pf_valid, pf_ready;
    logic [2:0]     dp_opcode, dp_errorCode, errCode;
    logic           dp_last, dp_respLast, dp_prRValid, dp_almostFull, dp_hasOutstanding;
    logic [1:0]     state;
    logic [ECW-1:0] errCnt;

    prefetch_op_sched dut (
        .clk(clk), .reset(reset),
        .crs_enable(crs_enable), .crs_flush(crs_flush), .crs_clearErr(crs_clearErr),
        .m_ar_valid(m_ar_valid), .m_ar_addr(m_ar_addr), .m_ar_ready(m_ar_ready),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_last(m_r_last),
        .s_r_valid(s_r_valid), .s_r_data(s_r_data), .s_r_last(s_r_last), .s_r_ready(s_r_ready),
        .pf_valid(pf_valid), .pf_addr(pf_addr), .pf_ready(pf_ready),
        .dp_opcode(dp_opcode), .dp_addr(dp_addr), .dp_data(dp_data), .dp_last(dp_last),
        .dp_respData(dp_respData), .dp_respLast(dp_respLast), .dp_prRValid(dp_prRValid),
        .dp_almostFull(dp_almostFull), .dp_hasOutstanding(dp_hasOutstanding),
        .dp_errorCode(dp_errorCode),
        .state(state), .errCode(errCode), .errCnt(errCnt)
    );

    int checkCnt = 0;
    int passCnt  = 0;

    // Reference model: state as 0..3, whether AR currently wins a tie, previous opcode, error regs.
    int mState, mLastOp, mErrCode, mErrCnt;
    bit mFavourAr;
    int expOp;
    bit expBoth;
    int obsOp, obsState, obsReadies;
    logic [AW-1:0] obsAddr;

    task automatic chk(input string tag, input logic [BLK-1:0] got, input logic [BLK-1:0] exp);
        checkCnt++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else passCnt++;
    endtask

    function automatic logic [BLK-1:0] randBlk();
        logic [BLK-1:0] v;
        for (int k = 0; k < BLK / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic clearIn(input bit en);
        crs_enable = en; crs_flush = 0; crs_clearErr = 0;
        m_ar_valid = 0; m_r_ready = 0; s_r_valid = 0; s_r_last = 0; pf_valid = 0;
        dp_respLast = 0; dp_prRValid = 0; dp_almostFull = 0; dp_hasOutstanding = 0;
        dp_errorCode = 0;
        m_ar_addr = {$urandom, $urandom}; pf_addr = {$urandom, $urandom};
        s_r_data = randBlk(); dp_respData = randBlk();
    endtask

    task automatic randIn();
        crs_enable   = ($urandom_range(0, 99) < 85);
        crs_flush    = ($urandom_range(0, 99) < 5);
        crs_clearErr = ($urandom_range(0, 99) < 10);
        m_ar_valid   = $urandom_range(0, 1);
        m_r_ready    = $urandom_range(0, 1);
        s_r_valid    = ($urandom_range(0, 99) < 30);
        s_r_last     = $urandom_range(0, 1);
        pf_valid     = $urandom_range(0, 1);
        dp_respLast  = $urandom_range(0, 1);
        dp_prRValid  = $urandom_range(0, 1);
        dp_almostFull     = ($urandom_range(0, 99) < 30);
        dp_hasOutstanding = $urandom_range(0, 1);
        dp_errorCode = ($urandom_range(0, 99) < 8) ? 3'($urandom_range(1, 4)) : 3'd0;
        m_ar_addr = {$urandom, $urandom}; pf_addr = {$urandom, $urandom};
        s_r_data = randBlk(); dp_respData = randBlk();
    endtask

    // Expected grant from the priority rules: slave R, then AR/promise tie-break, then prefetch.
    task automatic evalModel();
        bit notErr, run, arC, prC;
        notErr  = (mState != 3);
        run     = (mState == 1);
        arC     = run && m_ar_valid;
        prC     = notErr && dp_prRValid && m_r_ready;
        expBoth = 0;
        if (reset) expOp = 0;
        else if (notErr && s_r_valid) expOp = 3;
        else if (arC && prC) begin
            expBoth = 1;
            expOp = mFavourAr ? 2 : 4;
        end
        else if (arC) expOp = 2;
        else if (prC) expOp = 4;
        else if (run && pf_valid && !dp_almostFull) expOp = 1;
        else expOp = 0;
    endtask

    task automatic updateModel();
        bit q, clr;
        int ns;
        if (reset) begin
            mState = 0; mFavourAr = 1; mLastOp = 0; mErrCode = 0; mErrCnt = 0;
        end else begin
            q   = (dp_errorCode != 0) && !(dp_errorCode == 1 && mLastOp == 0);
            clr = (mState == 3) && crs_clearErr;
            ns  = mState;
            if (mState != 3 && q) ns = 3;
            else if (mState == 0 && crs_enable) ns = 1;
            else if (mState == 1 && (crs_flush || !crs_enable)) ns = 2;
            else if (mState == 2 && !dp_hasOutstanding && !dp_prRValid) ns = 0;
            else if (mState == 3 && crs_clearErr) ns = 0;
            if (clr) mErrCode = 0;
            else if (mErrCode == 0 && q) mErrCode = dp_errorCode;
            if (clr) mErrCnt = 0;
            else if (q && mErrCnt < (1 << ECW) - 1) mErrCnt++;
            if (expBoth) mFavourAr = (expOp == 4);
            mLastOp = expOp;
            mState  = ns;
        end
    endtask

    task automatic runCycle();
        int eCnt;
        @(negedge clk);
        evalModel();
        obsOp = int'(dp_opcode);
        obsState = int'(state);
        obsReadies = {29'd0, s_r_ready, m_ar_ready, pf_ready};
        obsAddr = dp_addr;
`ifdef PREFETCH_OP_SCHED_ERRCNT_EN
        eCnt = reset ? 0 : mErrCnt;
`else
        eCnt = 0;
`endif
        chk("opcode", dp_opcode, expOp);
        chk("readies", obsReadies, {expOp == 3, expOp == 2, expOp == 1});
        chk("m_r_valid", m_r_valid, !reset && mState != 3 && dp_prRValid);
        chk("dp_addr", dp_addr, (expOp == 2) ? m_ar_addr : (expOp == 1) ? pf_addr : '0);
        chk("dp_data", dp_data, (expOp == 3) ? s_r_data : '0);
        chk("dp_last", dp_last, (expOp == 3) && s_r_last);
        chk("m_r_data", {m_r_data, m_r_last}, {dp_respData, dp_respLast});
        chk("state", state, reset ? 0 : mState);
        chk("errCode", errCode, reset ? 0 : mErrCode);
        chk("errCnt", errCnt, eCnt);
        @(posedge clk);
        updateModel();
        #1;
    endtask

    initial begin
        clearIn(0);
        reset = 1;
        mState = 0; mFavourAr = 1; mLastOp = 0; mErrCode = 0; mErrCnt = 0;
        repeat (2) @(posedge clk);
        #1;
        runCycle();
        reset = 0;

        // IDLE -> RUN, then slave R beats everything.
        clearIn(1); runCycle();
        s_r_valid = 1; m_ar_valid = 1; pf_valid = 1; runCycle();
        chk("sr_priority", obsOp, 3);

        // AR and promise read both pending: alternate starting with AR.
        clearIn(1); m_ar_valid = 1; dp_prRValid = 1; m_r_ready = 1;
        for (int i = 0; i < 4; i++) begin
            runCycle();
            chk("rr_seq", obsOp, (i % 2 == 0) ? 2 : 4);
        end

        // Prefetch held off by almostFull, then issued.
        clearIn(1); pf_valid = 1; dp_almostFull = 1; runCycle();
        chk("pf_full", obsOp, 0);
        dp_almostFull = 0; runCycle();
        chk("pf_go", obsOp, 1);
        chk("pf_addr", obsAddr, pf_addr);

        // Bad opcode after NOP is ignored; full after AR latches ERROR.
        clearIn(1); runCycle();
        dp_errorCode = 1; runCycle();
        chk("nop_err_ignored", state, 1);
        clearIn(1); m_ar_valid = 1; runCycle();
        clearIn(1); dp_errorCode = 2; runCycle();
        chk("err_state", state, 3);
        chk("err_code", errCode, 2);
`ifdef PREFETCH_OP_SCHED_ERRCNT_EN
        chk("err_cnt", errCnt, 1);
`else
        chk("err_cnt", errCnt, 0);
`endif
        clearIn(0); crs_clearErr = 1; runCycle();
        chk("clear_state", state, 0);
        chk("clear_code", errCode, 0);

        // Flush into DRAIN, hold while outstanding, then back to IDLE.
        clearIn(1); runCycle();
        crs_flush = 1; dp_hasOutstanding = 1; m_ar_valid = 1; runCycle();
        crs_flush = 0; crs_enable = 0;
        for (int i = 0; i < 3; i++) begin
            runCycle();
            chk("drain_state", obsState, 2);
            chk("drain_arready", obsReadies, 0);
        end
        dp_hasOutstanding = 0; runCycle();
        runCycle();
        chk("drain_done", obsState, 0);

        // Reset in the middle of active grants.
        clearIn(1); runCycle();
        m_ar_valid = 1; pf_valid = 1; dp_prRValid = 1; m_r_ready = 1; s_r_valid = 1; runCycle();
        reset = 1; runCycle();
        chk("rst_op", obsOp, 0);
        chk("rst_readies", obsReadies, 0);
        reset = 0; clearIn(0); runCycle();
        chk("rst_state", obsState, 0);
        chk("rst_code", errCode, 0);

        for (int i = 0; i < 3000; i++) begin
            randIn();
            reset = ($urandom_range(0, 199) == 0);
            runCycle();
        end
        reset = 0;

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
